// File: rtl/axi4_adrs_sequencer.sv
// rtl/axi4_adrs_sequencer.sv - AXI4 AR/AW burst address walker for DDR memory test passes
// Optional LFSR random order is compiled in with AXI4_ADRS_LFSR_EN.
module axi4_adrs_sequencer #(
  parameter int pDataBitWidth = 16,
  parameter int pBurstLen     = 16,
  parameter int pRowBitWidth  = 14,
  parameter int pBankBitWidth = 3,
  parameter int pColBitWidth  = 10,
  parameter int pAdrsBitWidth = 33,
  parameter int pPassBitWidth = 8
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     iStart,
  input  logic                     iStop,
  input  logic [1:0]               iMode,
  input  logic [pPassBitWidth-1:0] iPassNum,
  input  logic [31:0]              iSeed,
  output logic                     oAxValid,
  input  logic                     iAxReady,
  output logic [pAdrsBitWidth-1:0] oAdrs,
  output logic [7:0]               oAxLen,
  output logic                     oBusy,
  output logic                     oPassDone,
  output logic                     oDone,
  output logic [pPassBitWidth-1:0] oPassCnt
);

  localparam int lpDpBits    = $clog2(pDataBitWidth / 8);
  localparam int lpBurstBits = $clog2(pBurstLen);
  localparam int lpColHiBits = pColBitWidth - lpBurstBits;
  localparam int lpIdxBits   = pRowBitWidth + pBankBitWidth + lpColHiBits;
  localparam int lpPadBits   = pAdrsBitWidth - lpIdxBits - lpBurstBits - lpDpBits;

  typedef enum logic [1:0] {sIdle, sRun, sDone} stateT;

  stateT                    state, stateNxt;
  logic [lpIdxBits-1:0]     burstIdx;
  logic [lpIdxBits-1:0]     linIdx;
  logic [pPassBitWidth-1:0] passCnt;
  logic [pPassBitWidth-1:0] passNum;
  logic [1:0]               mode;
  logic                     stopPend;
  logic                     start, hs, finish;
  logic                     lastBurst, lastPass;

  assign lastBurst = &burstIdx;
  assign lastPass  = (passNum != '0) && ((passCnt + pPassBitWidth'(1)) == passNum);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= sIdle;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    oAxValid = 1'b0;
    oBusy    = 1'b0;
    oDone    = 1'b0;
    start    = 1'b0;
    hs       = 1'b0;
    finish   = 1'b0;
    case (state)
      sIdle: begin
        if (iStart) begin
          start    = 1'b1;
          stateNxt = sRun;
        end
      end
      sRun: begin
        oAxValid = 1'b1;
        oBusy    = 1'b1;
        hs       = iAxReady;
        // a stop only takes effect once the beat on the bus has been accepted
        finish   = hs & ((lastBurst & lastPass) | iStop | stopPend);
        if (finish) stateNxt = sDone;
      end
      sDone: begin
        oBusy    = 1'b1;
        oDone    = 1'b1;
        stateNxt = sIdle;
      end
      default: stateNxt = sIdle;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      burstIdx <= '0;
      passCnt  <= '0;
      passNum  <= '0;
      mode     <= 2'd0;
      stopPend <= 1'b0;
    end else if (start) begin
      burstIdx <= '0;
      passCnt  <= '0;
      passNum  <= iPassNum;
      mode     <= iMode;
      stopPend <= 1'b0;
    end else if (state == sRun) begin
      if (iStop) stopPend <= 1'b1;
      if (hs) begin
        burstIdx <= burstIdx + lpIdxBits'(1);
        if (lastBurst) passCnt <= passCnt + pPassBitWidth'(1);
      end
    end
  end

`ifdef AXI4_ADRS_LFSR_EN
  logic [31:0] lfsr;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)     lfsr <= '0;
    else if (start)  lfsr <= (iSeed == 32'h0) ? 32'h1 : iSeed;
    else if (hs)     lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  end
`else
  logic unusedSeed;
  assign unusedSeed = ^iSeed;
`endif

  // linIdx is always {row, bank, colHi}; interleave only reorders the counter bits
  always_comb begin
    linIdx = burstIdx;
    if (mode == 2'd1)
      linIdx = {burstIdx[lpIdxBits-1 -: pRowBitWidth],
                burstIdx[0 +: pBankBitWidth],
                burstIdx[pBankBitWidth +: lpColHiBits]};
`ifdef AXI4_ADRS_LFSR_EN
    if (mode == 2'd2)
      linIdx = lfsr[lpIdxBits-1:0];
`endif
  end

  assign oAdrs     = {{lpPadBits{1'b0}}, linIdx, {(lpBurstBits + lpDpBits){1'b0}}};
  assign oAxLen    = 8'(pBurstLen - 1);
  assign oPassDone = hs & lastBurst;
  assign oPassCnt  = passCnt;

endmodule
